// File: rtl/bn_sqrt_arbiter_if.sv
// Request/response bundle between BN-channel requesters and the shared sqrt arbiter.
// master = requester/consumer side, slave = arbiter side.
interface bn_sqrt_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/bn_sqrt_arbiter.sv
// Round-robin share of one iterative FP16 sqrt core among NUM_REQ BN requesters.
// Optional SQRT_ZERO_BYPASS_EN answers +-0 and negative operands without starting the core.
module bn_sqrt_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bn_sqrt_arbiter_if.slave      bus,
  output logic                  core_reset_o,
  output logic [DATA_WIDTH-1:0] core_x_o,
  input  logic [DATA_WIDTH-1:0] core_result_i,
  input  logic                  core_finished_i,
  output logic                  busy_o
);

  localparam int                    CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] QNAN    = DATA_WIDTH'(16'h7E00);
  localparam logic [ID_W-1:0]       PTR_RST = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]      CNT_TO  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e                state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  core_reset_q;
  logic                  busy_q;

  logic                  gnt_vld_d;
  logic [ID_W-1:0]       gnt_id_d;
  logic [DATA_WIDTH-1:0] gnt_x_d;
  logic                  hs_d;
  logic [NUM_REQ-1:0]    req_ready_d;

  // Search ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_id_d  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld_d && bus.req_valid[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          gnt_vld_d = 1'b1;
          gnt_id_d  = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_x_d     = '0;
    req_ready_d = '0;
    hs_d        = (state_q == IDLE) && !reset_i && gnt_vld_d;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_d == ID_W'(i)) begin
        gnt_x_d        = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_d[i] = hs_d;
      end
    end
  end

`ifdef SQRT_ZERO_BYPASS_EN
  logic byp_zero_d;
  logic byp_neg_d;
  assign byp_zero_d = (gnt_x_d[DATA_WIDTH-2:0] == '0);
  assign byp_neg_d  = gnt_x_d[DATA_WIDTH-1] && !byp_zero_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      id_q         <= '0;
      cnt_q        <= '0;
      x_q          <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            x_q    <= gnt_x_d;
            id_q   <= gnt_id_d;
            ptr_q  <= gnt_id_d;
            busy_q <= 1'b1;
`ifdef SQRT_ZERO_BYPASS_EN
            if (byp_zero_d) begin
              rsp_data_q  <= gnt_x_d;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (byp_neg_d) begin
              rsp_data_q  <= QNAN;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= LOAD;
            end
`else
            state_q <= LOAD;
`endif
          end
        end
        LOAD: begin
          cnt_q        <= '0;
          core_reset_q <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_finished_i) begin
            rsp_data_q   <= core_result_i;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            core_reset_q <= 1'b1;
            state_q      <= RESP;
          end else if (cnt_q == CNT_TO) begin
            rsp_data_q   <= QNAN;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            core_reset_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign core_reset_o  = core_reset_q;
  assign core_x_o      = x_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_bn_sqrt_arbiter.sv
// Scoreboard bench for bn_sqrt_arbiter with a behavioural sqrt-core stand-in.
// Bypass expectations follow SQRT_ZERO_BYPASS_EN when the bench is built with it.
module tb_bn_sqrt_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  logic core_reset, core_finished, busy;
  logic [DW-1:0] core_x, core_result;

  always #5 clk = ~clk;

  bn_sqrt_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bif ();

  bn_sqrt_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .bus            (bif),
    .core_reset_o   (core_reset),
    .core_x_o       (core_x),
    .core_result_i  (core_result),
    .core_finished_i(core_finished),
    .busy_o         (busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(string name);
    n_total++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Core stand-in: a few exact square roots, otherwise a fixed mock mapping.
  function automatic logic [DW-1:0] mock_sqrt(logic [DW-1:0] x);
    case (x)
      16'h4400: return 16'h4000;
      16'h3C00: return 16'h3C00;
      16'h4C00: return 16'h4400;
      16'h4880: return 16'h4200;
      16'h3400: return 16'h3800;
      default:  return ((x & 16'h7FFF) >> 1) + 16'h1E00;
    endcase
  endfunction

  logic core_hang;
  logic [3:0] core_cnt;
  always @(posedge clk) begin
    if (core_reset) core_cnt <= 4'd0;
    else if (core_cnt != 4'hF) core_cnt <= core_cnt + 4'd1;
  end
  assign core_finished = !core_reset && !core_hang && (core_cnt == 4'd5);
  assign core_result   = core_finished ? mock_sqrt(core_x) : 16'hDEAD;

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    logic        err;
    int          lat;
    logic        bypass;
    logic [DW-1:0] x;
  } exp_t;

  exp_t expq[$];
  int   grants[$];
  int   mptr = NR - 1;
  bit   model_idle = 1;
  bit   resp_seen = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   n_rsp = 0;
  bit   keep = 0;
  logic [NR-1:0] granted = '0;

  function automatic int rr_pick(logic [NR-1:0] v, int p);
    for (int k = 1; k <= NR; k++) begin
      int idx = (p + k) % NR;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic exp_t predict(int g, logic [DW-1:0] x, logic hang);
    exp_t e;
    e.id = g; e.x = x; e.bypass = 1'b0;
`ifdef SQRT_ZERO_BYPASS_EN
    if (x[14:0] == 15'd0) begin
      e.data = x; e.err = 1'b0; e.lat = 1; e.bypass = 1'b1;
      return e;
    end
    if (x[15]) begin
      e.data = 16'h7E00; e.err = 1'b1; e.lat = 1; e.bypass = 1'b1;
      return e;
    end
`endif
    if (hang) begin
      e.data = 16'h7E00; e.err = 1'b1; e.lat = 2 + TO;
    end else begin
      e.data = mock_sqrt(x); e.err = 1'b0; e.lat = 8;
    end
    return e;
  endfunction

  // Monitor: predicts grants, checks responses against the queue head.
  always @(negedge clk) begin
    int g;
    exp_t e;
    cyc++;
    if (reset) begin
      chk("ready_in_reset", 32'(bif.req_ready), 32'd0);
      expq.delete();
      model_idle = 1; mptr = NR - 1; resp_seen = 0; granted = '0;
    end else if (model_idle) begin
      chk("rsp_valid_idle", 32'(bif.rsp_valid), 32'd0);
      chk("core_reset_idle", 32'(core_reset), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      g = rr_pick(bif.req_valid, mptr);
      if (g >= 0) begin
        chk("req_ready_grant", 32'(bif.req_ready), 32'(1) << g);
        e = predict(g, bif.req_data[g*DW +: DW], core_hang);
        expq.push_back(e);
        grants.push_back(g);
        mptr = g; model_idle = 0; hs_cyc = cyc; resp_seen = 0;
        granted = granted | (NR'(1) << g);
      end else begin
        chk("req_ready_none", 32'(bif.req_ready), 32'd0);
      end
    end else begin
      e = expq[0];
      chk("req_ready_busy", 32'(bif.req_ready), 32'd0);
      chk("busy_active", 32'(busy), 32'd1);
      if (core_reset === 1'b0)
        chk("core_run_x", {15'd0, e.bypass, core_x}, {15'd0, 1'b0, e.x});
      if (bif.rsp_valid) begin
        if (!resp_seen) begin
          chk("latency", 32'(cyc - hs_cyc), 32'(e.lat));
          resp_seen = 1;
        end
        chk("rsp_id", 32'(bif.rsp_id), 32'(e.id));
        chk("rsp_data", 32'(bif.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(bif.rsp_err), 32'(e.err));
        if (bif.rsp_ready) begin
          void'(expq.pop_front());
          n_rsp++;
          model_idle = 1;
        end
      end else if (!resp_seen && (cyc - hs_cyc > e.lat + 4)) begin
        fail("rsp_missing");
        void'(expq.pop_front());
        model_idle = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (granted[i]) begin
        if (keep) bif.req_data[i*DW +: DW] = 16'($urandom);
        else bif.req_valid[i] = 1'b0;
      end
    end
    granted = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(int max, string name);
    int n = 0;
    while (!(model_idle && expq.size() == 0 && bif.req_valid == '0)) begin
      step();
      n++;
      if (n > max) begin
        fail(name);
        bif.req_valid = '0;
        return;
      end
    end
    step();
  endtask

  task automatic wait_grant(int max, string name);
    int n0 = grants.size();
    int n = 0;
    while (grants.size() == n0) begin
      step();
      n++;
      if (n > max) begin fail(name); return; end
    end
  endtask

  task automatic issue(int r, logic [DW-1:0] x);
    bif.req_data[r*DW +: DW] = x;
    bif.req_valid[r] = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    core_hang = 1'b0;
    bif.req_valid = '0;
    bif.req_data = '0;
    bif.rsp_ready = 1'b1;
    step(); step();
    chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bif.rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(bif.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_x", 32'(core_x), 32'd0);
    reset = 1'b0;

    // Single request: sqrt(4.0)
    issue(0, 16'h4400);
    wait_idle(40, "wait_single");
    chk("single_rsp_count", 32'(n_rsp), 32'd1);
    chk("single_busy_after", 32'(busy), 32'd0);

    // All requesters continuously valid: rotation 0,1,2,3,0
    do_reset();
    grants.delete();
    keep = 1;
    for (int i = 0; i < NR; i++) issue(i, 16'($urandom));
    n = 0;
    while (grants.size() < 5 && n < 100) begin step(); n++; end
    keep = 0;
    bif.req_valid = '0;
    wait_idle(40, "wait_rr");
    if (grants.size() < 5) fail("rr_grants");
    else for (int k = 0; k < 5; k++) chk("rr_order", 32'(grants[k]), 32'(k % NR));

    // Core never finishes -> timeout, then a normal request
    core_hang = 1'b1;
    issue(2, 16'h3C00);
    wait_idle(60, "wait_timeout");
    core_hang = 1'b0;
    issue(3, 16'h4880);
    wait_idle(40, "wait_after_timeout");

    // Consumer stalls 10 cycles in RESP while other requesters wait
    bif.rsp_ready = 1'b0;
    issue(1, 16'h4C00);
    wait_grant(20, "wait_stall_grant");
    bif.req_valid = 4'b1101;
    n = 0;
    while (!bif.rsp_valid && n < 40) begin step(); n++; end
    repeat (10) step();
    chk("stall_rsp_held", 32'(bif.rsp_valid), 32'd1);
    bif.req_valid = '0;
    bif.rsp_ready = 1'b1;
    wait_idle(40, "wait_stall");

    // Reset in the middle of RUN
    issue(3, 16'h3400);
    wait_grant(20, "wait_mid_grant");
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NR; i++) issue(i, 16'($urandom));
    wait_grant(20, "wait_post_reset");
    chk("post_reset_winner", 32'(grants[grants.size()-1]), 32'd0);
    wait_idle(120, "wait_post_reset_drain");

`ifdef SQRT_ZERO_BYPASS_EN
    issue(0, 16'h8000);
    wait_idle(20, "wait_byp_negzero");
    issue(1, 16'hC000);
    wait_idle(20, "wait_byp_neg");
    issue(2, 16'h0000);
    wait_idle(20, "wait_byp_zero");
`endif

    // Randomised traffic with stalls, drops and occasional hangs
    for (int c = 0; c < 600; c++) begin
      step();
      bif.rsp_ready = ($urandom_range(3) != 0);
      if (model_idle && expq.size() == 0) core_hang = ($urandom_range(7) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!bif.req_valid[i] && $urandom_range(3) == 0) issue(i, 16'($urandom));
        else if (bif.req_valid[i] && $urandom_range(15) == 0) bif.req_valid[i] = 1'b0;
      end
    end
    bif.req_valid = '0;
    bif.rsp_ready = 1'b1;
    wait_idle(60, "wait_random_drain");
    core_hang = 1'b0;
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
